// File: rtl/xevious_clk_pkg.sv
// Shared types and constants for the Xevious clock/reset sequencer.
// Holds the sequencer state encoding, divider defaults and a width helper.
package xevious_clk_pkg;

  typedef enum logic [1:0] {
    WAIT_LOCK = 2'd0,
    STABLE    = 2'd1,
    HOLD      = 2'd2,
    RUN       = 2'd3
  } seq_state_t;

  // Defaults for the 48 MHz system clock.
  localparam int CE_DIV_48M      = 8;
  localparam int LOCK_STABLE_48M = 1024;
  localparam int RESET_HOLD_48M  = 256;

  // Smallest r with 2**r >= v.
  function automatic int clog2(input int v);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < v) r = i + 1;
    end
    return r;
  endfunction

  function automatic int imax(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/sync_2ff.sv
// One-bit two-flop synchronizer for inputs arriving from another clock domain.
module sync_2ff (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic meta;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta <= 1'b0;
      q    <= 1'b0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/clk_reset_seq.sv
// Core reset sequencer: waits for a stable PLL lock, holds the core in reset
// with clock enables running, then releases it; re-sequences on lock loss or soft reset.
module clk_reset_seq
  import xevious_clk_pkg::*;
#(
  parameter int LOCK_STABLE_CYCLES = LOCK_STABLE_48M,
  parameter int RESET_HOLD_CYCLES  = RESET_HOLD_48M,
  parameter int CE_DIV             = CE_DIV_48M
) (
  input  logic clk,
  input  logic rst_n,
  input  logic pll_locked,
  input  logic soft_reset,
  output logic core_reset,
  output logic ce_pix,
  output logic ce_cpu,
  output logic ready,
  output logic lock_lost
);

  localparam int CNT_W = clog2(imax(LOCK_STABLE_CYCLES, RESET_HOLD_CYCLES));
  localparam int DIV_W = clog2(2 * CE_DIV);
  localparam int PIX_W = clog2(CE_DIV);

  localparam logic [CNT_W-1:0] LOCK_TERM = CNT_W'(LOCK_STABLE_CYCLES - 1);
  localparam logic [CNT_W-1:0] HOLD_TERM = CNT_W'(RESET_HOLD_CYCLES - 1);
  localparam logic [DIV_W-1:0] CPU_TERM  = DIV_W'(2 * CE_DIV - 1);
  localparam logic [PIX_W-1:0] PIX_TERM  = PIX_W'(CE_DIV - 1);

  seq_state_t       state, state_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic [DIV_W-1:0] div;
  logic             lock_s;
  logic             lock_lost_nxt;
  logic             active, active_nxt;

  sync_2ff u_lock_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .d     (pll_locked),
    .q     (lock_s)
  );

  // Lock loss beats soft reset, which beats the count terminal.
  always_comb begin
    state_nxt     = state;
    cnt_nxt       = cnt;
    lock_lost_nxt = lock_lost;
    case (state)
      WAIT_LOCK: begin
        cnt_nxt = '0;
        if (lock_s) state_nxt = STABLE;
      end
      STABLE: begin
        if (!lock_s) begin
          state_nxt = WAIT_LOCK;
          cnt_nxt   = '0;
        end else if (cnt == LOCK_TERM) begin
          state_nxt = HOLD;
          cnt_nxt   = '0;
        end else begin
          cnt_nxt = cnt + 1'b1;
        end
      end
      HOLD: begin
        if (!lock_s) begin
          state_nxt = WAIT_LOCK;
          cnt_nxt   = '0;
        end else if (soft_reset) begin
          cnt_nxt       = '0;
          lock_lost_nxt = 1'b0;
        end else if (cnt == HOLD_TERM) begin
          state_nxt = RUN;
          cnt_nxt   = '0;
        end else begin
          cnt_nxt = cnt + 1'b1;
        end
      end
      RUN: begin
        cnt_nxt = '0;
        if (!lock_s) begin
          state_nxt     = WAIT_LOCK;
          lock_lost_nxt = 1'b1;
        end else if (soft_reset) begin
          state_nxt     = HOLD;
          lock_lost_nxt = 1'b0;
        end
      end
      default: begin
        state_nxt = WAIT_LOCK;
        cnt_nxt   = '0;
      end
    endcase
  end

  assign active     = (state == HOLD) || (state == RUN);
  assign active_nxt = (state_nxt == HOLD) || (state_nxt == RUN);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= WAIT_LOCK;
      cnt       <= '0;
      lock_lost <= 1'b0;
      core_reset <= 1'b1;
      ready     <= 1'b0;
    end else begin
      state     <= state_nxt;
      cnt       <= cnt_nxt;
      lock_lost <= lock_lost_nxt;
      core_reset <= (state_nxt != RUN);
      ready     <= (state_nxt == RUN);
    end
  end

  // div keeps running across a soft reset so the enable phase never breaks;
  // enables are gated by the next state so none leaks into WAIT_LOCK/STABLE.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div    <= '0;
      ce_pix <= 1'b0;
      ce_cpu <= 1'b0;
    end else begin
      div    <= active ? div + 1'b1 : '0;
      ce_pix <= active_nxt && (div[PIX_W-1:0] == PIX_TERM);
      ce_cpu <= active_nxt && (div == CPU_TERM);
    end
  end

endmodule
